// File: rtl/mmio_responder_pkg.sv
// MMIO responder shared definitions.
// Window base, register offsets and status bit positions.
package psp_mmio_pkg;

  localparam logic [31:0] MMIO_BASE_DEF = 32'hF000_0000;

  localparam logic [7:0] OFF_LED        = 8'h00;
  localparam logic [7:0] OFF_EXIT       = 8'h04;
  localparam logic [7:0] OFF_CYCLE_LO   = 8'h08;
  localparam logic [7:0] OFF_CYCLE_HI   = 8'h0C;
  localparam logic [7:0] OFF_CON_TX     = 8'h10;
  localparam logic [7:0] OFF_CON_STATUS = 8'h14;

  localparam int ST_FULL  = 8;
  localparam int ST_EMPTY = 9;
  localparam int ST_OVF   = 16;

  function automatic logic in_window(
    input logic [31:0] addr,
    input logic [31:0] base
  );
    return addr[31:8] == base[31:8];
  endfunction

endpackage

// File: rtl/mmio_responder_if.sv
// Core dmem bus plus main-memory port B forwarding.
// slave: responder view; master: core/memory side.
interface mmio_responder_if;
  logic [31:0] core_addr;
  logic [31:0] core_data_i;
  logic [31:0] core_data_o;
  logic        core_data_en;
  logic [3:0]  core_write_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_data_i;
  logic [31:0] mem_data_o;
  logic        mem_data_en;
  logic [3:0]  mem_write_en;

  modport slave (
    input  core_addr, core_data_i,
    input  core_data_en, core_write_en,
    input  mem_data_o,
    output core_data_o,
    output mem_addr, mem_data_i,
    output mem_data_en, mem_write_en
  );

  modport master (
    output core_addr, core_data_i,
    output core_data_en, core_write_en,
    output mem_data_o,
    input  core_data_o,
    input  mem_addr, mem_data_i,
    input  mem_data_en, mem_write_en
  );
endinterface

// File: rtl/mmio_responder_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers.
// Push while full is accepted only alongside a pop.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wp;
  logic [AW:0]      r_rp;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_count   = r_wp - r_rp;
  assign o_full    = (o_count == FULL_CNT);
  assign o_empty   = (o_count == '0);
  assign o_rdata   = r_mem[r_rp[AW-1:0]];
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (w_do_push) r_wp <= r_wp + 1'b1;
      if (w_do_pop)  r_rp <= r_rp + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wp[AW-1:0]] <= i_wdata;
  end
endmodule

// File: rtl/mmio_responder.sv
// Data-memory MMIO responder: LED, exit, cycle counter, console.
// Non-window accesses pass straight through to memory port B.
module mmio_responder
  import psp_mmio_pkg::*;
#(
  parameter logic [31:0] MMIO_BASE = MMIO_BASE_DEF,
  parameter int          CON_DEPTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  mmio_responder_if.slave   bus,
  output logic [3:0]        led,
  output logic              done,
  output logic [31:0]       exit_code,
  output logic [7:0]        con_data,
  output logic              con_valid,
  input  logic              con_ready
);
  localparam int CW = $clog2(CON_DEPTH) + 1;

  logic        w_hit;
  logic        w_wr;
  logic        w_rd;
  logic [7:0]  w_off;
  logic        w_push;
  logic        w_pop;
  logic        w_full;
  logic        w_empty;
  logic [CW-1:0] w_count;
  logic [31:0] w_status;
  logic [31:0] w_rdata;

  logic [63:0] r_cycle;
  logic [31:0] r_shadow;
  logic        r_ovf;
  logic        r_sel;
  logic [31:0] r_rdata;
  logic [3:0]  r_led;
  logic        r_done;
  logic [31:0] r_exit;

  assign w_hit = bus.core_data_en & in_window(bus.core_addr, MMIO_BASE);
  assign w_wr  = |bus.core_write_en;
  assign w_rd  = w_hit & ~w_wr;
  assign w_off = bus.core_addr[7:0];

  assign bus.mem_addr     = bus.core_addr;
  assign bus.mem_data_i   = bus.core_data_i;
  assign bus.mem_data_en  = bus.core_data_en & ~w_hit;
  assign bus.mem_write_en = w_hit ? 4'b0 : bus.core_write_en;
  assign bus.core_data_o  = r_sel ? r_rdata : bus.mem_data_o;

  assign w_push = w_hit & w_wr & (w_off == OFF_CON_TX);
  assign w_pop  = con_valid & con_ready;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (CON_DEPTH)
  ) u_con_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_wdata (bus.core_data_i[7:0]),
    .i_pop   (w_pop),
    .o_rdata (con_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign con_valid = ~w_empty;

  always_comb begin
    w_status           = '0;
    w_status[CW-1:0]   = w_count;
    w_status[ST_FULL]  = w_full;
    w_status[ST_EMPTY] = w_empty;
    w_status[ST_OVF]   = r_ovf;
  end

  always_comb begin
    w_rdata = '0;
    unique case (w_off)
      OFF_LED:        w_rdata = {28'b0, r_led};
      OFF_EXIT:       w_rdata = {31'b0, r_done};
      OFF_CYCLE_LO:   w_rdata = r_cycle[31:0];
      OFF_CYCLE_HI:   w_rdata = r_shadow;
      OFF_CON_STATUS: w_rdata = w_status;
      default:        w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cycle  <= '0;
      r_shadow <= '0;
      r_ovf    <= 1'b0;
      r_sel    <= 1'b0;
      r_rdata  <= '0;
      r_led    <= '0;
      r_done   <= 1'b0;
      r_exit   <= '0;
    end else begin
      r_cycle <= r_cycle + 64'd1;
      r_sel   <= w_hit;
      r_rdata <= w_rdata;
      // HI shadow makes a LO-then-HI read pair atomic
      if (w_rd && w_off == OFF_CYCLE_LO)
        r_shadow <= r_cycle[63:32];
      if (w_hit && w_wr) begin
        if (w_off == OFF_LED)
          r_led <= bus.core_data_i[3:0];
        if (w_off == OFF_EXIT) begin
          r_done <= 1'b1;
          r_exit <= bus.core_data_i;
        end
        if (w_off == OFF_CON_STATUS && bus.core_data_i[ST_OVF])
          r_ovf <= 1'b0;
      end
      if (w_push && w_full && !w_pop)
        r_ovf <= 1'b1;
    end
  end

  assign led       = r_led;
  assign done      = r_done;
  assign exit_code = r_exit;
endmodule

// File: tb/tb_mmio_responder.sv
// Directed bench for mmio_responder.
// Expected values are hand-computed constants.
module tb_mmio_responder;
  logic       clk;
  logic       reset;
  logic [3:0] led;
  logic       done;
  logic [31:0] exit_code;
  logic [7:0] con_data;
  logic       con_valid;
  logic       con_ready;

  int n_chk;
  int n_fail;

  mmio_responder_if bus ();

  mmio_responder dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.slave),
    .led       (led),
    .done      (done),
    .exit_code (exit_code),
    .con_data  (con_data),
    .con_valid (con_valid),
    .con_ready (con_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    bus.core_data_en  = 1'b0;
    bus.core_write_en = 4'h0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.core_addr     = a;
    bus.core_data_i   = d;
    bus.core_data_en  = 1'b1;
    bus.core_write_en = 4'hF;
    @(posedge clk);
    #1 idle();
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.core_addr     = a;
    bus.core_data_en  = 1'b1;
    bus.core_write_en = 4'h0;
    @(posedge clk);
    #1 idle();
    d = bus.core_data_o;
  endtask

  logic [31:0] v;

  initial begin
    n_chk  = 0;
    n_fail = 0;
    reset  = 1'b1;
    con_ready = 1'b0;
    bus.core_addr   = '0;
    bus.core_data_i = '0;
    bus.mem_data_o  = '0;
    idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_led", 64'(led), 64'h0);
    chk("rst_done", 64'(done), 64'h0);
    chk("rst_exit", 64'(exit_code), 64'h0);
    chk("rst_cvalid", 64'(con_valid), 64'h0);
    chk("rst_rdata", 64'(bus.core_data_o), 64'h0);
    reset = 1'b0;

    // passthrough read
    @(negedge clk);
    bus.core_addr     = 32'h0000_0100;
    bus.core_data_en  = 1'b1;
    bus.core_write_en = 4'h0;
    bus.mem_data_o    = 32'hDEAD_BEEF;
    #1;
    chk("pt_en", 64'(bus.mem_data_en), 64'h1);
    chk("pt_addr", 64'(bus.mem_addr), 64'h100);
    chk("pt_we", 64'(bus.mem_write_en), 64'h0);
    @(posedge clk);
    #1 idle();
    chk("pt_rdata", 64'(bus.core_data_o), 64'hDEAD_BEEF);

    // MMIO write is hidden from memory; LED write
    @(negedge clk);
    bus.mem_data_o    = 32'h1234_5678;
    bus.core_addr     = 32'hF000_0000;
    bus.core_data_i   = 32'hFFFF_FFF5;
    bus.core_data_en  = 1'b1;
    bus.core_write_en = 4'hF;
    #1;
    chk("mm_en", 64'(bus.mem_data_en), 64'h0);
    chk("mm_we", 64'(bus.mem_write_en), 64'h0);
    @(posedge clk);
    #1 idle();
    chk("led", 64'(led), 64'h5);
    rd(32'hF000_0000, v);
    chk("led_rd", 64'(v), 64'h5);

    // exit
    wr(32'hF000_0004, 32'h600D);
    chk("done", 64'(done), 64'h1);
    chk("exit_code", 64'(exit_code), 64'h600D);
    rd(32'hF000_0004, v);
    chk("exit_rd", 64'(v), 64'h1);
    repeat (3) @(posedge clk);
    #1;
    chk("done_sticky", 64'(done), 64'h1);
    chk("exit_sticky", 64'(exit_code), 64'h600D);
    rd(32'hF000_0020, v);
    chk("unmapped_rd", 64'(v), 64'h0);

    // counter atomicity across the LO->HI carry
    @(negedge clk);
    force dut.r_cycle = 64'h0000_0001_FFFF_FFFF;
    bus.core_addr     = 32'hF000_0008;
    bus.core_data_en  = 1'b1;
    bus.core_write_en = 4'h0;
    @(posedge clk);
    #1;
    release dut.r_cycle;
    idle();
    chk("cyc_lo", 64'(bus.core_data_o), 64'hFFFF_FFFF);
    rd(32'hF000_000C, v);
    chk("cyc_hi", 64'(v), 64'h1);

    // console FIFO overflow and drain
    for (int i = 0; i < 9; i++)
      wr(32'hF000_0010, 32'hAB00 | 32'(i));
    rd(32'hF000_0014, v);
    chk("st_full", 64'(v), 64'h0001_0108);
    rd(32'hF000_0010, v);
    chk("tx_rd0", 64'(v), 64'h0);
    @(negedge clk);
    chk("cv_full", 64'(con_valid), 64'h1);
    con_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk($sformatf("con_byte%0d", i), 64'(con_data), 64'(i));
      chk($sformatf("con_vld%0d", i), 64'(con_valid), 64'h1);
      @(negedge clk);
    end
    chk("cv_drained", 64'(con_valid), 64'h0);
    con_ready = 1'b0;
    rd(32'hF000_0014, v);
    chk("st_empty", 64'(v), 64'h0001_0200);
    wr(32'hF000_0014, 32'h0001_0000);
    rd(32'hF000_0014, v);
    chk("st_ovf_clr", 64'(v), 64'h0000_0200);

    // reset during an outstanding MMIO read
    wr(32'hF000_0000, 32'hA);
    wr(32'hF000_0010, 32'h42);
    rd(32'hF000_0008, v);
    @(negedge clk);
    bus.core_addr     = 32'hF000_0000;
    bus.core_data_en  = 1'b1;
    bus.core_write_en = 4'h0;
    bus.mem_data_o    = 32'h0;
    @(posedge clk);
    #1 idle();
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    chk("mr_rdata", 64'(bus.core_data_o), 64'h0);
    chk("mr_led", 64'(led), 64'h0);
    chk("mr_done", 64'(done), 64'h0);
    chk("mr_exit", 64'(exit_code), 64'h0);
    chk("mr_cvalid", 64'(con_valid), 64'h0);
    rd(32'hF000_0014, v);
    chk("mr_status", 64'(v), 64'h0000_0200);
    rd(32'hF000_000C, v);
    chk("mr_shadow", 64'(v), 64'h0);
    rd(32'hF000_0008, v);
    chk("mr_cycle", 64'(v), 64'h2);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
